// File: rtl/scytale_decryption_pkg.sv
// rtl/scytale_decryption_pkg.sv - shared crypt defaults and FSM state encoding
// Used by the scytale channel, the other decryption channels and the output mux.
package scytale_decryption_pkg;

   localparam int D_WIDTH_DEF       = 8;
   localparam int KEY_WIDTH_DEF     = 8;
   localparam int MAX_NOF_CHARS_DEF = 50;
   localparam logic [7:0] TOKEN_DEF = 8'hFA;

   typedef enum logic {
      COLLECT = 1'b0,
      DECRYPT = 1'b1
   } state_t;

endpackage

// File: rtl/scytale_addr_gen.sv
// rtl/scytale_addr_gen.sv - add-only read index generator for scytale transposition
// Walks idx = j*N + c column by column; idx saturates so out-of-buffer positions never alias.
module scytale_addr_gen #(
   parameter int KEY_WIDTH = 8,
   parameter int IDX_W     = 7
)(
   input  logic                 clk_sys,
   input  logic                 rst,
   input  logic [KEY_WIDTH-1:0] key_n,
   input  logic [KEY_WIDTH-1:0] key_m,
   input  logic                 start,
   input  logic                 adv,
   output logic [IDX_W-1:0]     rd_idx,
   output logic                 last
);

   localparam int SUM_W = KEY_WIDTH + IDX_W;
   localparam logic [SUM_W-1:0]     IDX_MAX = SUM_W'({IDX_W{1'b1}});
   localparam logic [KEY_WIDTH-1:0] ONE     = KEY_WIDTH'(1);

   logic [KEY_WIDTH-1:0] c;
   logic [KEY_WIDTH-1:0] j;
   logic [IDX_W-1:0]     idx;
   logic [SUM_W-1:0]     step_sum;
   logic [SUM_W-1:0]     wrap_sum;
   logic [IDX_W-1:0]     idx_step;
   logic [IDX_W-1:0]     idx_wrap;
   logic                 col_end;

   assign step_sum = SUM_W'(idx) + SUM_W'(key_n);
   assign wrap_sum = SUM_W'(c) + SUM_W'(1);
   assign idx_step = (step_sum > IDX_MAX) ? {IDX_W{1'b1}} : step_sum[IDX_W-1:0];
   assign idx_wrap = (wrap_sum > IDX_MAX) ? {IDX_W{1'b1}} : wrap_sum[IDX_W-1:0];
   assign col_end  = (j == key_m - ONE);
   assign last     = col_end && (c == key_n - ONE);
   assign rd_idx   = idx;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         c   <= '0;
         j   <= '0;
         idx <= '0;
      end else if (start) begin
         c   <= '0;
         j   <= '0;
         idx <= '0;
      end else if (adv) begin
         if (col_end) begin
            j   <= '0;
            c   <= c + ONE;
            idx <= idx_wrap;
         end else begin
            j   <= j + ONE;
            idx <= idx_step;
         end
      end
   end

endmodule

// File: rtl/scytale_decryption.sv
// rtl/scytale_decryption.sv - scytale decryption channel: buffer, FSM and output registers
// Optional sticky overflow_o port enabled by SCYTALE_OVERFLOW_FLAG_EN.
module scytale_decryption
   import scytale_decryption_pkg::*;
#(
   parameter int D_WIDTH       = D_WIDTH_DEF,
   parameter int KEY_WIDTH     = KEY_WIDTH_DEF,
   parameter int MAX_NOF_CHARS = MAX_NOF_CHARS_DEF,
   parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(TOKEN_DEF)
)(
   input  logic                 clk_sys,
   input  logic                 rst,
   input  logic [D_WIDTH-1:0]   data_i,
   input  logic                 valid_i,
   input  logic [KEY_WIDTH-1:0] key_N,
   input  logic [KEY_WIDTH-1:0] key_M,
   output logic [D_WIDTH-1:0]   data_o,
   output logic                 valid_o,
   output logic                 busy
`ifdef SCYTALE_OVERFLOW_FLAG_EN
   ,
   output logic                 overflow_o
`endif
);

   localparam int BUF_AW = $clog2(MAX_NOF_CHARS);
   localparam int IDX_W  = BUF_AW + 1;
   localparam logic [IDX_W-1:0] FULL = IDX_W'(MAX_NOF_CHARS);

   state_t               state, state_d;
   logic [IDX_W-1:0]     count, count_d;
   logic [KEY_WIDTH-1:0] key_n_q, key_n_d, key_m_q, key_m_d;
   logic                 start_q, start_d, fin, fin_d;
   logic                 busy_d, valid_d, wr_en, adv, last, go;
   logic                 is_tok, is_chr;
   logic [D_WIDTH-1:0]   data_d, rd_data;
   logic [IDX_W-1:0]     rd_idx;
   logic [D_WIDTH-1:0]   buf_mem [2**BUF_AW];
`ifdef SCYTALE_OVERFLOW_FLAG_EN
   logic                 ovf_d;
`endif

   assign is_tok  = valid_i && (data_i == START_DECRYPTION_TOKEN);
   assign is_chr  = valid_i && (data_i != START_DECRYPTION_TOKEN);
   assign go      = is_tok && (count != '0) && (key_N != '0) && (key_M != '0);
   assign rd_data = (rd_idx < count) ? buf_mem[rd_idx[BUF_AW-1:0]] : '0;

   scytale_addr_gen #(
      .KEY_WIDTH (KEY_WIDTH),
      .IDX_W     (IDX_W)
   ) u_addr_gen (
      .clk_sys (clk_sys),
      .rst     (rst),
      .key_n   (key_n_q),
      .key_m   (key_m_q),
      .start   (start_q),
      .adv     (adv),
      .rd_idx  (rd_idx),
      .last    (last)
   );

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) state <= COLLECT;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         COLLECT: if (go) state_d = DECRYPT;
         DECRYPT: if (fin) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // DECRYPT runs three phases: start_q (arm addr gen), busy emit, fin (clear down)
   always_comb begin
      count_d = count;
      key_n_d = key_n_q;
      key_m_d = key_m_q;
      start_d = 1'b0;
      fin_d   = fin;
      busy_d  = busy;
      valid_d = 1'b0;
      data_d  = '0;
      wr_en   = 1'b0;
      adv     = 1'b0;
`ifdef SCYTALE_OVERFLOW_FLAG_EN
      ovf_d   = overflow_o;
`endif
      case (state)
         COLLECT: begin
            if (is_chr) begin
               if (count != FULL) begin
                  wr_en   = 1'b1;
                  count_d = count + IDX_W'(1);
               end
`ifdef SCYTALE_OVERFLOW_FLAG_EN
               else begin
                  ovf_d = 1'b1;
               end
`endif
            end
            if (is_tok) begin
               key_n_d = key_N;
               key_m_d = key_M;
               start_d = go;
            end
         end
         DECRYPT: begin
            if (start_q) begin
               busy_d = 1'b1;
            end else if (fin) begin
               busy_d  = 1'b0;
               fin_d   = 1'b0;
               count_d = '0;
`ifdef SCYTALE_OVERFLOW_FLAG_EN
               ovf_d   = 1'b0;
`endif
            end else if (busy) begin
               valid_d = 1'b1;
               data_d  = rd_data;
               adv     = 1'b1;
               fin_d   = last;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         count   <= '0;
         key_n_q <= '0;
         key_m_q <= '0;
         start_q <= 1'b0;
         fin     <= 1'b0;
         busy    <= 1'b0;
         valid_o <= 1'b0;
         data_o  <= '0;
      end else begin
         count   <= count_d;
         key_n_q <= key_n_d;
         key_m_q <= key_m_d;
         start_q <= start_d;
         fin     <= fin_d;
         busy    <= busy_d;
         valid_o <= valid_d;
         data_o  <= data_d;
      end
   end

`ifdef SCYTALE_OVERFLOW_FLAG_EN
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) overflow_o <= 1'b0;
      else     overflow_o <= ovf_d;
   end
`endif

   always_ff @(posedge clk_sys) begin
      if (wr_en) buf_mem[count[BUF_AW-1:0]] <= data_i;
   end

endmodule

// File: tb/tb_scytale_decryption.sv
// tb/tb_scytale_decryption.sv - bench for scytale_decryption against a queue-based transposition model
// Also exercises overflow_o when SCYTALE_OVERFLOW_FLAG_EN is defined.
module tb_scytale_decryption;

   typedef logic [7:0] bq_t[$];

   logic       clk_sys = 1'b0;
   logic       rst;
   logic [7:0] data_i, key_N, key_M, data_o;
   logic       valid_i, valid_o, busy;
`ifdef SCYTALE_OVERFLOW_FLAG_EN
   logic       overflow_o;
`endif

   int   tests = 0;
   int   fails = 0;
   bq_t  model;
   logic ovf_exp;

   always #5 clk_sys = ~clk_sys;

   scytale_decryption dut (
      .clk_sys (clk_sys),
      .rst     (rst),
      .data_i  (data_i),
      .valid_i (valid_i),
      .key_N   (key_N),
      .key_M   (key_M),
      .data_o  (data_o),
      .valid_o (valid_o),
      .busy    (busy)
`ifdef SCYTALE_OVERFLOW_FLAG_EN
      ,
      .overflow_o (overflow_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ovf(input string tag);
`ifdef SCYTALE_OVERFLOW_FLAG_EN
      chk({tag, "_ovf"}, 32'(overflow_o), 32'(ovf_exp));
`endif
   endtask

   // Plaintext position (c, j) reads ciphertext index j*N + c; beyond the stored text is zero.
   function automatic bq_t expected(input int n, input int m);
      bq_t r;
      for (int c = 0; c < n; c++)
         for (int j = 0; j < m; j++) begin
            int idx = j * n + c;
            r.push_back(idx < model.size() ? model[idx] : 8'h00);
         end
      return r;
   endfunction

   function automatic bq_t str2q(input string s);
      bq_t r;
      for (int i = 0; i < s.len(); i++) r.push_back(s[i]);
      return r;
   endfunction

   function automatic bq_t rnd_msg(input int len);
      bq_t r;
      for (int i = 0; i < len; i++) r.push_back(8'($urandom % 250));
      return r;
   endfunction

   task automatic send(input logic [7:0] d);
      @(negedge clk_sys);
      chk_ovf("collect");
      valid_i = 1'b1;
      data_i  = d;
      if (model.size() < 50) model.push_back(d);
      else                   ovf_exp = 1'b1;
   endtask

   task automatic run_msg(input bq_t msg, input int n, input int m, input bit noise, input string tag);
      bq_t exp;
      bit  go;
      foreach (msg[i]) send(msg[i]);
      @(negedge clk_sys);
      chk_ovf(tag);
      valid_i = 1'b1;
      data_i  = 8'hFA;
      key_N   = 8'(n);
      key_M   = 8'(m);
      go  = (model.size() != 0) && (n != 0) && (m != 0);
      exp = expected(n, m);
      @(negedge clk_sys);
      valid_i = 1'b0;
      key_N   = 8'($urandom);
      key_M   = 8'($urandom);
      chk({tag, "_busy_t0"}, 32'(busy), 32'(0));
      chk({tag, "_valid_t0"}, 32'(valid_o), 32'(0));
      if (!go) begin
         repeat (3) begin
            @(negedge clk_sys);
            chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
            chk({tag, "_idle_valid"}, 32'(valid_o), 32'(0));
         end
         return;
      end
      @(negedge clk_sys);
      chk({tag, "_busy_t1"}, 32'(busy), 32'(1));
      chk({tag, "_valid_t1"}, 32'(valid_o), 32'(0));
      for (int k = 0; k < n * m; k++) begin
         @(negedge clk_sys);
         chk({tag, "_valid"}, 32'(valid_o), 32'(1));
         chk({tag, "_data"}, 32'(data_o), 32'(exp[k]));
         chk({tag, "_busy"}, 32'(busy), 32'(1));
         chk_ovf(tag);
         if (noise) begin
            valid_i = 1'($urandom);
            data_i  = ($urandom % 4 == 0) ? 8'hFA : 8'($urandom);
         end
      end
      @(negedge clk_sys);
      valid_i = 1'b0;
      model.delete();
      ovf_exp = 1'b0;
      chk({tag, "_end_valid"}, 32'(valid_o), 32'(0));
      chk({tag, "_end_busy"}, 32'(busy), 32'(0));
      chk({tag, "_end_data"}, 32'(data_o), 32'(0));
      chk_ovf({tag, "_end"});
   endtask

   initial begin
      bq_t empty, abc, exp5;
      int  n, m;
      rst = 1'b1; valid_i = 1'b0; data_i = '0; key_N = '0; key_M = '0; ovf_exp = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("rst_data", 32'(data_o), 32'(0));
      chk("rst_valid", 32'(valid_o), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk_ovf("rst");
      rst = 1'b0;

      run_msg(str2q("ABCDEF"), 2, 3, 1'b0, "s1");
      run_msg(str2q("ABCD"), 3, 2, 1'b0, "s2");
      run_msg(empty, 2, 3, 1'b0, "s3_empty");
      run_msg(empty, 0, 3, 1'b0, "s3_keyzero");
      run_msg(str2q("XY"), 1, 2, 1'b0, "s3_xy");
      run_msg(rnd_msg(53), 5, 10, 1'b0, "s4_full");

      // Asynchronous reset while the third plaintext character is on the output.
      abc = str2q("ABCDEF");
      foreach (abc[i]) send(abc[i]);
      @(negedge clk_sys);
      valid_i = 1'b1; data_i = 8'hFA; key_N = 8'd2; key_M = 8'd3;
      exp5 = expected(2, 3);
      @(negedge clk_sys);
      valid_i = 1'b0;
      repeat (4) @(negedge clk_sys);
      chk("s5_third_valid", 32'(valid_o), 32'(1));
      chk("s5_third_data", 32'(data_o), 32'(exp5[2]));
      #2 rst = 1'b1;
      #1;
      chk("s5_async_valid", 32'(valid_o), 32'(0));
      chk("s5_async_busy", 32'(busy), 32'(0));
      chk("s5_async_data", 32'(data_o), 32'(0));
      @(negedge clk_sys);
      rst = 1'b0;
      model.delete();
      ovf_exp = 1'b0;
      chk_ovf("s5_after_rst");
      run_msg(str2q("ABCDEF"), 2, 3, 1'b0, "s5_again");

      run_msg(rnd_msg(20), 4, 6, 1'b1, "s6_noise");
      run_msg(rnd_msg(9), 3, 3, 1'b0, "s6_clean");

      for (int t = 0; t < 8; t++) begin
         n = int'($urandom_range(1, 12));
         m = int'($urandom_range(1, 12));
         run_msg(rnd_msg(int'($urandom_range(1, 55))), n, m, 1'($urandom), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
